// File: rtl/tt_debounce_pkg.sv
// Shared types, defaults and sizing helper for the input debounce stage.
package tt_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } chan_state_e;

    localparam int unsigned DEFAULT_PRESCALE     = 1000;
    localparam int unsigned DEFAULT_STABLE_COUNT = 4;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: two-flop synchroniser, tick-sampled stability FSM and
// registered level/edge outputs.
module debounce_channel
    import tt_debounce_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CW = width_of(STABLE_COUNT + 1);

    logic          s1;
    logic          s2;
    chan_state_e   state_q;
    chan_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          clean_d;
    logic          rise_d;
    logic          fall_d;
    logic          busy_d;

    // Synchroniser keeps running regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean   <= clean_d;
            rise    <= rise_d;
            fall    <= fall_d;
            busy    <= busy_d;
        end
    end

    // Compare happens before increment, so cnt never exceeds STABLE_COUNT-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_inc = cnt_q + CW'(1);

        if (!ena) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                STABLE: begin
                    if (s2 != clean) begin
                        if (STABLE_COUNT == 1) begin
                            clean_d = s2;
                            rise_d  = s2;
                            fall_d  = ~s2;
                        end else begin
                            state_d = COUNT;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                COUNT: begin
                    if (s2 == clean) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(STABLE_COUNT)) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        clean_d = s2;
                        rise_d  = s2;
                        fall_d  = ~s2;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == COUNT);
    end

endmodule

// File: rtl/tt_input_debounce.sv
// Input conditioning for the latch design: shared sample prescaler feeding
// one debounce lane per raw input bit.
module tt_input_debounce
    import tt_debounce_pkg::*;
#(
    parameter int unsigned WIDTH        = 2,
    parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
    parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned PW = width_of(PRESCALE);

    logic [PW-1:0] pcnt_q;
    logic          tick_c;

    assign tick_c = ena && (pcnt_q == PW'(PRESCALE - 1));

    // Held at zero while disabled so the first tick lands PRESCALE cycles after ena rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (!ena || tick_c) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PW'(1);
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
        debounce_channel #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .ena  (ena),
            .tick (tick_c),
            .raw  (raw_in[i]),
            .clean(clean[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .busy (busy[i])
        );
    end

endmodule

// File: tb/tb_tt_input_debounce.sv
// Scoreboard bench: two debounce instances (sample every cycle / every third
// cycle) driven in lockstep and compared against a sample-window model.
module tb_tt_input_debounce;

    localparam int unsigned SC = 4;

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
    } obs_t;

    typedef struct packed {
        obs_t i1;
        obs_t i0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] raw_in;
    logic [1:0] clean0, rise0, fall0, busy0;
    logic [1:0] clean1, rise1, fall1, busy1;

    always #5 clk = ~clk;

    tt_input_debounce #(.WIDTH(2), .PRESCALE(1), .STABLE_COUNT(SC)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in),
        .clean(clean0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    tt_input_debounce #(.WIDTH(2), .PRESCALE(3), .STABLE_COUNT(SC)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_in(raw_in),
        .clean(clean1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: a level is accepted once the last SC tick samples since the
    // previous acceptance (or enable/reset) all disagree with the clean level.
    logic [1:0]    m_s1  [2];
    logic [1:0]    m_s2  [2];
    obs_t          m_out [2];
    int unsigned   m_run [2];
    logic [SC-1:0] m_win [2][2];
    int unsigned   m_n   [2][2];

    function automatic int unsigned ps(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k]  = '0;
            m_s2[k]  = '0;
            m_out[k] = '0;
            m_run[k] = 0;
            for (int c = 0; c < 2; c++) begin
                m_win[k][c] = '0;
                m_n[k][c]   = 0;
            end
        end
    endfunction

    function automatic void model_step(input logic [1:0] r, input logic e, input logic rn);
        logic tick;
        if (!rn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            tick = e && ((m_run[k] % ps(k)) == ps(k) - 1);
            m_out[k].rise = '0;
            m_out[k].fall = '0;
            for (int c = 0; c < 2; c++) begin
                if (!e) begin
                    m_win[k][c] = '0;
                    m_n[k][c]   = 0;
                end else if (tick) begin
                    m_win[k][c] = (m_win[k][c] << 1) | SC'(m_s2[k][c]);
                    m_n[k][c]++;
                    if (m_n[k][c] >= SC && m_win[k][c] == {SC{~m_out[k].clean[c]}}) begin
                        m_out[k].clean[c] = m_s2[k][c];
                        if (m_s2[k][c]) m_out[k].rise[c] = 1'b1;
                        else            m_out[k].fall[c] = 1'b1;
                        m_n[k][c]   = 0;
                        m_win[k][c] = '0;
                    end
                end
                m_out[k].busy[c] = (m_n[k][c] > 0) && (m_win[k][c][0] != m_out[k].clean[c]);
            end
            m_run[k] = e ? m_run[k] + 1 : 0;
            m_s2[k]  = m_s1[k];
            m_s1[k]  = r;
        end
    endfunction

    function automatic void cmp_field(input int k, input string nm, input logic [1:0] got,
                                      input logic [1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL inst%0d %s got %b want %b at %0t", k, nm, got, want, $time);
        end
    endfunction

    function automatic void cmp_obs(input int k, input obs_t got, input obs_t want);
        cmp_field(k, "clean", got.clean, want.clean);
        cmp_field(k, "rise",  got.rise,  want.rise);
        cmp_field(k, "fall",  got.fall,  want.fall);
        cmp_field(k, "busy",  got.busy,  want.busy);
    endfunction

    // Monitor: every cycle the DUTs present a result, compared after the edge.
    initial begin
        exp_t e;
        obs_t a0, a1;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e  = sbq.pop_front();
                a0 = '{clean: clean0, rise: rise0, fall: fall0, busy: busy0};
                a1 = '{clean: clean1, rise: rise1, fall: fall1, busy: busy1};
                cmp_obs(0, a0, e.i0);
                cmp_obs(1, a1, e.i1);
            end
        end
    end

    task automatic drive(input logic [1:0] r, input logic e, input logic rn, input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            raw_in = r;
            ena    = e;
            if (!rn && rst_n) begin
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({clean0, rise0, fall0, busy0, clean1, rise1, fall1, busy1} !== 16'h0) begin
                    n_fail++;
                    $display("FAIL async_reset got %b %b %b %b / %b %b %b %b want all zero",
                             clean0, rise0, fall0, busy0, clean1, rise1, fall1, busy1);
                end
            end else begin
                rst_n = rn;
            end
            model_step(r, e, rn);
            x.i0 = m_out[0];
            x.i1 = m_out[1];
            sbq.push_back(x);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        raw_in = 2'b00;
        model_reset();

        // Reset held with inputs high, then release.
        drive(2'b11, 1'b1, 1'b0, 5);
        drive(2'b11, 1'b1, 1'b1, 16);
        // Clean step on channel 0.
        drive(2'b00, 1'b1, 1'b1, 16);
        drive(2'b01, 1'b1, 1'b1, 16);
        // Bounce rejection on channel 0.
        drive(2'b00, 1'b1, 1'b1, 16);
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, 1'b1, 1'b1, 2);
            drive(2'b00, 1'b1, 1'b1, 2);
        end
        drive(2'b00, 1'b1, 1'b1, 16);
        // Simultaneous opposite commits.
        drive(2'b10, 1'b1, 1'b1, 16);
        drive(2'b01, 1'b1, 1'b1, 16);
        // ena drop mid-count.
        drive(2'b00, 1'b1, 1'b1, 16);
        drive(2'b01, 1'b1, 1'b1, 4);
        drive(2'b01, 1'b0, 1'b1, 3);
        drive(2'b01, 1'b1, 1'b1, 16);
        // Reset mid-count.
        drive(2'b00, 1'b1, 1'b1, 16);
        drive(2'b11, 1'b1, 1'b1, 4);
        drive(2'b11, 1'b1, 1'b0, 2);
        drive(2'b11, 1'b1, 1'b1, 16);

        // Randomized segments of held inputs.
        for (int s = 0; s < 300; s++) begin
            logic [1:0] r;
            logic       e;
            logic       rn;
            r  = 2'($urandom);
            e  = ($urandom_range(0, 9) != 0);
            rn = ($urandom_range(0, 39) != 0);
            drive(r, e, rn, int'($urandom_range(1, 24)));
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
